// File: rtl/sprite_compositor_if.sv
// Bundle of per-pixel inputs, sprite attributes, sync-ROM bus and colour outputs of sprite_compositor.
// The master modport drives pixel and sprite inputs. The slave modport is the compositor.
interface sprite_compositor_if #(
  parameter int unsigned NUM_SPR  = 8,
  parameter int unsigned W_LOG2   = 5,
  parameter int unsigned H_LOG2   = 5,
  parameter int unsigned FRM_LOG2 = 2
);
  localparam int unsigned ADDR_W = FRM_LOG2 + W_LOG2 + H_LOG2;
  localparam int unsigned ID_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  logic                         pix_valid_i;
  logic                         frame_start_i;
  logic [9:0]                   DrawX;
  logic [9:0]                   DrawY;
  logic [NUM_SPR-1:0]           spr_en;
  logic [10*NUM_SPR-1:0]        spr_x;
  logic [10*NUM_SPR-1:0]        spr_y;
  logic [FRM_LOG2*NUM_SPR-1:0]  spr_frm;
  logic [23:0]                  bg_rgb;
  logic [ADDR_W*NUM_SPR-1:0]    rom_addr;
  logic [24*NUM_SPR-1:0]        rom_data;
  logic [7:0]                   VGA_R;
  logic [7:0]                   VGA_G;
  logic [7:0]                   VGA_B;
  logic                         pix_valid_o;
  logic [ID_W-1:0]              hit_id;
  logic                         hit_any;
  logic [NUM_SPR-1:0]           collision;

  modport master (
    output pix_valid_i, frame_start_i, DrawX, DrawY, spr_en, spr_x, spr_y, spr_frm, bg_rgb,
    output rom_data,
    input  rom_addr, VGA_R, VGA_G, VGA_B, pix_valid_o, hit_id, hit_any, collision
  );

  modport slave (
    input  pix_valid_i, frame_start_i, DrawX, DrawY, spr_en, spr_x, spr_y, spr_frm, bg_rgb,
    input  rom_data,
    output rom_addr, VGA_R, VGA_G, VGA_B, pix_valid_o, hit_id, hit_any, collision
  );
endinterface

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor, fixed 3-cycle latency: hit test/ROM address, texel fetch, priority pick.
// Define SPRITE_COLLISION_EN to build the sticky per-frame opaque-overlap collision flags.
module sprite_compositor #(
  parameter int unsigned NUM_SPR  = 8,
  parameter int unsigned W_LOG2   = 5,
  parameter int unsigned H_LOG2   = 5,
  parameter int unsigned FRM_LOG2 = 2,
  parameter logic [23:0] KEY_RGB  = 24'hFF0000
) (
  input logic              Clk,
  input logic              Reset_n,
  sprite_compositor_if.slave bus
);
  localparam int unsigned ADDR_W = FRM_LOG2 + W_LOG2 + H_LOG2;
  localparam int unsigned ID_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  logic [NUM_SPR-1:0]        w_hit;
  logic [ADDR_W*NUM_SPR-1:0] w_addr;
  logic [NUM_SPR-1:0]        w_op;

  logic [ADDR_W*NUM_SPR-1:0] r1_addr;
  logic [NUM_SPR-1:0]        r1_hit;
  logic [23:0]               r1_bg;
  logic                      r1_valid;
  logic [NUM_SPR-1:0]        r2_hit;
  logic [23:0]               r2_bg;
  logic                      r2_valid;
  logic [23:0]               r3_rgb;
  logic [ID_W-1:0]           r3_id;
  logic                      r3_any;
  logic                      r3_valid;

  logic [23:0]               w_win_rgb;
  logic [ID_W-1:0]           w_win_id;
  logic                      w_win_any;

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_chan
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    assign w_dx = {1'b0, bus.DrawX} - {1'b0, bus.spr_x[10*g +: 10]};
    assign w_dy = {1'b0, bus.DrawY} - {1'b0, bus.spr_y[10*g +: 10]};
    // All-zero upper bits means 0 <= d < 2**LOG2; a borrow sets bit 10, so no wrap-around hits.
    assign w_hit[g] = bus.spr_en[g] & bus.pix_valid_i
                    & (w_dx[10:W_LOG2] == '0) & (w_dy[10:H_LOG2] == '0);
    assign w_addr[ADDR_W*g +: ADDR_W] = w_hit[g]
        ? {bus.spr_frm[FRM_LOG2*g +: FRM_LOG2], w_dy[H_LOG2-1:0], w_dx[W_LOG2-1:0]}
        : '0;
    assign w_op[g] = r2_hit[g] & (bus.rom_data[24*g +: 24] != KEY_RGB);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r1_addr  <= '0;
      r1_hit   <= '0;
      r1_bg    <= '0;
      r1_valid <= 1'b0;
      r2_hit   <= '0;
      r2_bg    <= '0;
      r2_valid <= 1'b0;
    end else begin
      r1_addr  <= w_addr;
      r1_hit   <= w_hit;
      r1_bg    <= bus.bg_rgb;
      r1_valid <= bus.pix_valid_i;
      r2_hit   <= r1_hit;
      r2_bg    <= r1_bg;
      r2_valid <= r1_valid;
    end
  end

  assign bus.rom_addr = r1_addr;

  always_comb begin
    w_win_rgb = '0;
    w_win_id  = '0;
    w_win_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      if (w_op[i] && !w_win_any) begin
        w_win_rgb = bus.rom_data[24*i +: 24];
        w_win_id  = ID_W'(i);
        w_win_any = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r3_rgb   <= '0;
      r3_id    <= '0;
      r3_any   <= 1'b0;
      r3_valid <= 1'b0;
    end else begin
      r3_valid <= r2_valid;
      if (!r2_valid) begin
        r3_rgb <= '0;
        r3_id  <= '0;
        r3_any <= 1'b0;
      end else if (w_win_any) begin
        r3_rgb <= w_win_rgb;
        r3_id  <= w_win_id;
        r3_any <= 1'b1;
      end else begin
        r3_rgb <= r2_bg;
        r3_id  <= '0;
        r3_any <= 1'b0;
      end
    end
  end

  assign bus.VGA_R       = r3_rgb[23:16];
  assign bus.VGA_G       = r3_rgb[15:8];
  assign bus.VGA_B       = r3_rgb[7:0];
  assign bus.hit_id      = r3_id;
  assign bus.hit_any     = r3_any;
  assign bus.pix_valid_o = r3_valid;

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] r_coll;
  logic               w_multi;

  // Clearing x & (x-1) drops the lowest set bit; anything left means two or more opaque sprites.
  assign w_multi = |(w_op & (w_op - 1'b1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_coll <= '0;
    end else begin
      r_coll <= (bus.frame_start_i ? '0 : r_coll) | (w_multi ? w_op : '0);
    end
  end

  assign bus.collision = r_coll;
`else
  assign bus.collision = '0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus random pixels vs. an arithmetic model.
// Collision expectations follow SPRITE_COLLISION_EN when the bench is compiled with it.
module tb_sprite_compositor;
  localparam int NS = 8;
  localparam int WL = 5;
  localparam int HL = 5;
  localparam int FL = 2;
  localparam int AW = FL + WL + HL;
  localparam logic [23:0] KEY = 24'hFF0000;

  typedef struct {
    logic [AW*NS-1:0] addr;
    logic             valid;
    logic [23:0]      rgb;
    logic [2:0]       id;
    logic             any;
    logic [NS-1:0]    op;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  sprite_compositor_if #(.NUM_SPR(NS), .W_LOG2(WL), .H_LOG2(HL), .FRM_LOG2(FL)) bus ();

  sprite_compositor #(
    .NUM_SPR(NS), .W_LOG2(WL), .H_LOG2(HL), .FRM_LOG2(FL), .KEY_RGB(KEY)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  logic [23:0] rom [NS][1<<AW];

  // Synchronous ROM per channel: data follows the registered address by one clock.
  always @(posedge Clk) begin
    logic [24*NS-1:0] t;
    for (int i = 0; i < NS; i++) t[24*i +: 24] = rom[i][bus.rom_addr[AW*i +: AW]];
    bus.rom_data <= t;
  end

  logic [9:0]    sx [NS];
  logic [9:0]    sy [NS];
  logic [1:0]    sfrm [NS];
  logic [NS-1:0] en;
  logic [9:0]    drawx, drawy;
  logic          pv, fs;
  logic [23:0]   bg;

  exp_t          ring [4];
  logic          fs_ring [4];
  logic          rst_ring [4];
  logic [NS-1:0] coll_exp;
  int            n;
  int            total;
  int            bad;

  function automatic exp_t zero_exp();
    exp_t e;
    e.addr = '0; e.valid = 1'b0; e.rgb = '0; e.id = '0; e.any = 1'b0; e.op = '0;
    return e;
  endfunction

  // Reference: each sprite is a 32x32 window; pick the first opaque one, else background, else black.
  function automatic exp_t model();
    exp_t e;
    e = zero_exp();
    e.valid = pv;
    for (int i = 0; i < NS; i++) begin
      int ddx, ddy, a;
      ddx = int'(drawx) - int'(sx[i]);
      ddy = int'(drawy) - int'(sy[i]);
      if (en[i] && pv && ddx >= 0 && ddx < (1 << WL) && ddy >= 0 && ddy < (1 << HL)) begin
        a = int'(sfrm[i]) * (1 << (WL + HL)) + ddy * (1 << WL) + ddx;
        e.addr[AW*i +: AW] = a[AW-1:0];
        if (rom[i][a] != KEY) begin
          e.op[i] = 1'b1;
          if (!e.any) begin
            e.any = 1'b1;
            e.id  = i[2:0];
            e.rgb = rom[i][a];
          end
        end
      end
    end
    if (pv && !e.any) e.rgb = bg;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input exp_t ea, input exp_t eo);
    chk("rom_addr", 128'(bus.rom_addr), 128'(ea.addr));
    chk("rgb", 128'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 128'(eo.rgb));
    chk("hit_id", 128'(bus.hit_id), 128'(eo.id));
    chk("hit_any", 128'(bus.hit_any), 128'(eo.any));
    chk("pix_valid_o", 128'(bus.pix_valid_o), 128'(eo.valid));
    chk("collision", 128'(bus.collision), 128'(coll_exp));
  endtask

  task automatic step();
    exp_t e, ea, eo;
    bus.pix_valid_i   = pv;
    bus.frame_start_i = fs;
    bus.DrawX         = drawx;
    bus.DrawY         = drawy;
    bus.spr_en        = en;
    bus.bg_rgb        = bg;
    for (int i = 0; i < NS; i++) begin
      bus.spr_x[10*i +: 10]   = sx[i];
      bus.spr_y[10*i +: 10]   = sy[i];
      bus.spr_frm[FL*i +: FL] = sfrm[i];
    end
    e = Reset_n ? model() : zero_exp();
    ring[n % 4]     = e;
    fs_ring[n % 4]  = fs;
    rst_ring[n % 4] = Reset_n;
    @(posedge Clk);
    #1;
    n++;
    ea = ring[(n - 1) % 4];
    eo = ring[(n - 3) % 4];
`ifdef SPRITE_COLLISION_EN
    if (!rst_ring[(n - 1) % 4]) coll_exp = '0;
    else begin
      if (fs_ring[(n - 1) % 4]) coll_exp = '0;
      if ($countones(eo.op) >= 2) coll_exp = coll_exp | eo.op;
    end
`else
    coll_exp = '0;
`endif
    check_outputs(ea, eo);
  endtask

  task automatic idle(input int cycles);
    pv = 1'b0;
    fs = 1'b0;
    for (int k = 0; k < cycles; k++) step();
  endtask

  task automatic rand_pixel(input int xmax, input int ymax);
    pv    = ($urandom % 8) != 0;
    fs    = ($urandom % 60) == 0;
    drawx = 10'($urandom_range(0, xmax));
    drawy = 10'($urandom_range(0, ymax));
    bg    = 24'($urandom);
    if (($urandom % 6) == 0) begin
      int j;
      j = $urandom_range(0, NS - 1);
      sx[j]   = 10'($urandom_range(0, xmax));
      sy[j]   = 10'($urandom_range(0, ymax));
      sfrm[j] = 2'($urandom);
      en[j]   = ($urandom % 4) != 0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    n = 3;
    coll_exp = '0;
    for (int k = 0; k < 4; k++) begin
      ring[k] = zero_exp();
      fs_ring[k] = 1'b0;
      rst_ring[k] = 1'b0;
    end
    for (int i = 0; i < NS; i++) begin
      for (int a = 0; a < (1 << AW); a++) rom[i][a] = (($urandom % 4) == 0) ? KEY : 24'($urandom);
      sx[i] = '0; sy[i] = '0; sfrm[i] = '0;
    end
    en = '0; drawx = '0; drawy = '0; pv = 1'b0; fs = 1'b0; bg = 24'h102030;
    bus.rom_data = '0;

    // Reset held from time zero, then released.
    pv = 1'b1;
    for (int k = 0; k < 3; k++) step();
    Reset_n = 1'b1;
    idle(3);

    // Single sprite, texel at offset (5,3) in frame 2.
    sx[0] = 10'd100; sy[0] = 10'd50; sfrm[0] = 2'd2; en = 8'h01;
    rom[0][{2'd2, 5'd3, 5'd5}] = 24'h00FF00;
    pv = 1'b1; drawx = 10'd105; drawy = 10'd53; bg = 24'h0A0B0C;
    step();
    idle(3);

    // Sprites 0 and 3 overlap: keyed front sprite, then both opaque.
    sx[3] = 10'd100; sy[3] = 10'd50; sfrm[3] = 2'd2; en = 8'h09;
    rom[0][{2'd2, 5'd4, 5'd6}] = KEY;
    rom[3][{2'd2, 5'd4, 5'd6}] = 24'h1234AB;
    pv = 1'b1; drawx = 10'd106; drawy = 10'd54;
    step();
    rom[0][{2'd2, 5'd4, 5'd7}] = 24'h445566;
    rom[3][{2'd2, 5'd4, 5'd7}] = 24'h778899;
    drawx = 10'd107;
    step();
    idle(4);

    // Frame start with no overlap clears the flags.
    fs = 1'b1; step();
    idle(3);

    // Overlap pixel whose result lands on the same clock as the frame pulse.
    pv = 1'b1; drawx = 10'd107; drawy = 10'd54;
    step();
    pv = 1'b0;
    step();
    fs = 1'b1;
    step();
    idle(4);

    // Right-edge clipping: hit at DrawX=1023, no wrap to DrawX=2.
    en = 8'h02; sx[1] = 10'd1010; sy[1] = 10'd200; sfrm[1] = 2'd1;
    rom[1][{2'd1, 5'd5, 5'd13}] = 24'h5A5A5A;
    pv = 1'b1; drawy = 10'd205; drawx = 10'd1023;
    step();
    drawx = 10'd2;
    step();
    idle(3);

    // 640-pixel line with one blanked pixel in the middle.
    for (int i = 0; i < NS; i++) begin
      sx[i] = 10'($urandom_range(0, 620)); sy[i] = 10'($urandom_range(40, 70));
      sfrm[i] = 2'($urandom);
    end
    en = 8'hFF; drawy = 10'd60; bg = 24'h203040;
    for (int p = 0; p < 640; p++) begin
      drawx = 10'(p);
      pv = (p != 320);
      fs = 1'b0;
      step();
    end
    idle(3);

    // Random pixels concentrated on a small area so sprites overlap often.
    for (int k = 0; k < 700; k++) begin
      rand_pixel(150, 150);
      step();
    end

    // Reset mid-stream: outputs clear immediately, in-flight pixels are dropped.
    Reset_n = 1'b0;
    #1;
    chk("rst_rgb", 128'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 128'(0));
    chk("rst_pix_valid_o", 128'(bus.pix_valid_o), 128'(0));
    chk("rst_collision", 128'(bus.collision), 128'(0));
    chk("rst_rom_addr", 128'(bus.rom_addr), 128'(0));
    for (int k = 0; k < 4; k++) ring[k] = zero_exp();
    coll_exp = '0;
    for (int k = 0; k < 2; k++) begin
      rand_pixel(150, 150);
      step();
    end
    Reset_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      rand_pixel(150, 150);
      if (k % 50 == 0) begin
        drawx = 10'($urandom_range(990, 1023));
        sx[k % NS] = 10'($urandom_range(990, 1023));
      end
      step();
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
